instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Read-side initiator for the 16x20-bit register_file instruction store.
//  Walks a program counter, issues rd/address to register_file, captures out_data and
//  presents one instruction at a time to the decode stage over a valid/ready handshake.
//  Handles start, branch redirect and halt.
// PARAMETERS
//  ADDR_W   4   register_file address width; PC width
//  DATA_W   20  instruction word width (register_file data width)
// PORTS
//  clk            in   1       system clock; all logic on rising edge
//  reset          in   1       synchronous, active-high
//  start          in   1       IDLE only: load pc<=start_addr, begin fetching
//  start_addr     in   ADDR_W  first fetch address
//  redirect       in   1       branch taken: abandon in-flight fetch, restart at redirect_addr
//  redirect_addr  in   ADDR_W  branch target
//  halt           in   1       pulse: stop after the current instruction is accepted
//  mem_address    out  ADDR_W  to register_file.address
//  mem_rd         out  1       to register_file.rd
//  mem_wr         out  1       to register_file.wr; constant 0
//  mem_out_data   in   DATA_W  from register_file.out_data; valid 1 cycle after mem_rd
//  instr          out  DATA_W  fetched instruction
//  instr_pc       out  ADDR_W  address instr was fetched from
//  instr_valid    out  1       instr/instr_pc valid
//  instr_ready    in   1       decode accepts when instr_valid & instr_ready
//  busy           out  1       1 in any state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, pc=0, mem_address=0, mem_rd=0, instr=0, instr_pc=0, instr_valid=0,
//   halt_pend=0, busy=0. Reset mid-fetch discards everything. All outputs registered.
//  FSM: IDLE -> ISSUE -> WAIT -> VALID -> (ISSUE | IDLE).
//   IDLE : start=1 -> pc<=start_addr, ISSUE. redirect/halt ignored.
//   ISSUE: mem_rd=1, mem_address=pc for exactly one cycle -> WAIT.
//   WAIT : mem_out_data captured into instr, instr_pc<=pc, instr_valid<=1,
//          pc<=pc+1 mod 2^ADDR_W (4'hF wraps to 4'h0) -> VALID.
//   VALID: instr/instr_pc held stable while !instr_ready. On accept: instr_valid<=0;
//          halt_pend ? IDLE : ISSUE.
//  Throughput 1 instruction per 3 cycles with instr_ready=1; first instr_valid 3 cycles after start.
//  halt: sets sticky halt_pend in ISSUE/WAIT/VALID; in-flight instruction completes and is
//   presented; IDLE entered after its acceptance; halt_pend cleared on entering IDLE.
//  redirect (non-IDLE): pc<=redirect_addr, instr_valid<=0, mem_rd<=0, halt_pend<=0, -> ISSUE;
//   any read in flight is discarded. Redirect in VALID with instr_ready=1: the handshake
//   completes (current instr consumed) and the redirect still applies.
//  Priority per cycle: reset > redirect > halt > start.
//  start while busy: ignored.
// CONFIGURATION
//  FETCH_PERF_EN defined: fetch_count[15:0] (+1 per accepted instr) and
//   stall_count[15:0] (+1 per cycle instr_valid & !instr_ready), both saturate at 16'hFFFF,
//   cleared by reset only.
//  Not defined: both ports present, driven constant 0, no counter logic.
// STRUCTURE
//  fetch_pkg: state encoding localparams (S_IDLE=0,S_ISSUE=1,S_WAIT=2,S_VALID=3),
//   default ADDR_W/DATA_W.
//  Sub-module fetch_perf_counters (instantiated only under FETCH_PERF_EN).
//  Bench instantiates real register_file, preloads via wr port before releasing start.
// TESTING
//  1 Preload mem[0..3]=20'h00010,00011,00012,00013; start,start_addr=0, ready=1 ->
//    instr 00010..00013 with instr_pc 0..3, instr_valid every 3rd cycle, first at start+3.
//  2 instr_ready=0 for 5 cycles on pc=1 -> instr=20'h00011 stable, no mem_rd pulses;
//    stall_count=5 with FETCH_PERF_EN, 0 without.
//  3 start_addr=4'hE, mem[E]=20'hAAAAA, mem[F]=20'hBBBBB, mem[0]=20'hCCCCC ->
//    instr_pc E,F,0 in order (wrap).
//  4 redirect, redirect_addr=4'h8 during WAIT of pc=2 -> pc=2 word never shown;
//    next instr_valid has instr_pc=8, instr=mem[8].
//  5 halt pulse during ISSUE of pc=5 -> mem[5] presented, accepted, then busy=0,
//    no further mem_rd; later start resumes normally.
//  6 reset asserted during WAIT -> next cycle all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch unit:
//   - default PC / instruction widths matching the 16x20 register_file store
//   - FSM state encoding (IDLE=0, ISSUE=1, WAIT=2, VALID=3)
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int FETCH_ADDR_W = 4;
  localparam int FETCH_DATA_W = 20;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_VALID = 2'd3
  } fetch_state_t;

endpackage : fetch_pkg

// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Bundles the two buses of the fetch unit:
//   memory side : mem_address, mem_rd, mem_wr (out) / mem_out_data (in)
//   decode side : instr, instr_pc, instr_valid (out) / instr_ready (in)
// Modports:
//   master - the fetch unit
//   slave  - register_file + decode stage (or a testbench standing in for them)
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 20
);

  logic [ADDR_W-1:0] mem_address;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_out_data;

  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;

  modport master (
    output mem_address, mem_rd, mem_wr,
    input  mem_out_data,
    output instr, instr_pc, instr_valid,
    input  instr_ready
  );

  modport slave (
    input  mem_address, mem_rd, mem_wr,
    output mem_out_data,
    input  instr, instr_pc, instr_valid,
    output instr_ready
  );

endinterface : instr_fetch_unit_if

// File: rtl/fetch_perf_counters.sv
// -----------------------------------------------------------------------------
// fetch_perf_counters
// Saturating 16-bit event counters for the fetch unit; only compiled when
// FETCH_PERF_EN is defined.
//   clk, reset  : clock, synchronous active-high reset (the only clear)
//   accept      : one instruction handed to decode this cycle
//   stall       : instruction presented but not accepted this cycle
//   fetch_count : accepted instructions, sticks at 16'hFFFF
//   stall_count : stalled cycles, sticks at 16'hFFFF
// -----------------------------------------------------------------------------
`ifdef FETCH_PERF_EN
module fetch_perf_counters (
  input  logic        clk,
  input  logic        reset,
  input  logic        accept,
  input  logic        stall,
  output logic [15:0] fetch_count,
  output logic [15:0] stall_count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (accept && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
      if (stall  && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
  end

endmodule : fetch_perf_counters
`endif

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
// 16 x 20-bit instruction store with one shared address port.
//   clk, reset : clock, synchronous active-high reset (read register only)
//   address    : word address
//   wr,in_data : write strobe and data (written on the rising edge)
//   rd         : read strobe; out_data updates on the rising edge where rd=1,
//                so data is valid the cycle after rd
// -----------------------------------------------------------------------------
module register_file #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              rd,
  input  logic              wr,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the storage array is deliberately left out of reset so it maps onto
  // plain RAM/flops without a reset tree; only the read register is reset.
  always_ff @(posedge clk) begin
    if (wr) mem[address] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset)   out_data <= '0;
    else if (rd) out_data <= mem[address];
  end

endmodule : register_file

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Read-side initiator for the register_file instruction store. Walks a PC,
// issues one read per instruction and presents each word to decode over a
// valid/ready handshake. Sequence per instruction: ISSUE -> WAIT -> VALID.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start/start_addr  : in IDLE, begin fetching at start_addr
//   redirect/_addr    : branch taken, drop in-flight work, restart at target
//   halt              : stop after the current instruction is accepted
//   busy              : high in every state except IDLE
//   fetch_count       : accepted instructions   (FETCH_PERF_EN only, else 0)
//   stall_count       : valid & !ready cycles   (FETCH_PERF_EN only, else 0)
//   bus (master)      : register_file read port and decode handshake
// Build option: define FETCH_PERF_EN to include the performance counters.
// -----------------------------------------------------------------------------
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              halt,
  output logic              busy,
  output logic [15:0]       fetch_count,
  output logic [15:0]       stall_count,
  instr_fetch_unit_if.master bus
);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic              halt_pend, halt_pend_nxt;
  logic              capture;
  logic              accept;

  logic [ADDR_W-1:0] mem_address_q;
  logic              mem_rd_q;
  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic              instr_valid_q;

  assign accept = instr_valid_q & bus.instr_ready;

  // Next-state logic. Redirect outranks halt; start only matters in IDLE.
  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    halt_pend_nxt = halt_pend;
    capture       = 1'b0;

    if (state == S_IDLE) begin
      if (start) begin
        pc_nxt    = start_addr;
        state_nxt = S_ISSUE;
      end
    end else if (redirect) begin
      // Re-entering ISSUE launches a fresh read at the target; the old read
      // data (if any) is simply never captured.
      pc_nxt        = redirect_addr;
      halt_pend_nxt = 1'b0;
      state_nxt     = S_ISSUE;
    end else begin
      if (halt) halt_pend_nxt = 1'b1;
      case (state)
        S_ISSUE: state_nxt = S_WAIT;
        S_WAIT: begin
          capture   = 1'b1;
          pc_nxt    = pc + ADDR_W'(1);
          state_nxt = S_VALID;
        end
        S_VALID: begin
          if (accept) begin
            // A halt arriving in the accept cycle still stops the fetch.
            if (halt_pend || halt) begin
              halt_pend_nxt = 1'b0;
              state_nxt     = S_IDLE;
            end else begin
              state_nxt = S_ISSUE;
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      pc            <= '0;
      halt_pend     <= 1'b0;
      mem_address_q <= '0;
      mem_rd_q      <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      halt_pend <= halt_pend_nxt;
      // Outputs are decoded from the next state so they line up with the state.
      mem_rd_q      <= (state_nxt == S_ISSUE);
      instr_valid_q <= (state_nxt == S_VALID);
      if (state_nxt == S_ISSUE) mem_address_q <= pc_nxt;
      if (capture) begin
        instr_q    <= bus.mem_out_data;
        instr_pc_q <= pc;
      end
    end
  end

  assign bus.mem_address = mem_address_q;
  assign bus.mem_rd      = mem_rd_q;
  assign bus.mem_wr      = 1'b0;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign busy            = (state != S_IDLE);

`ifdef FETCH_PERF_EN
  fetch_perf_counters u_perf (
    .clk         (clk),
    .reset       (reset),
    .accept      (accept),
    .stall       (instr_valid_q & ~bus.instr_ready),
    .fetch_count (fetch_count),
    .stall_count (stall_count)
  );
`else
  assign fetch_count = 16'd0;
  assign stall_count = 16'd0;
`endif

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Drives instr_fetch_unit against a real register_file. Expected instructions
// are pushed into a queue as each program is launched; a monitor pops and
// compares on every accepted handshake.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  typedef struct {
    logic [19:0] instr;
    logic [3:0]  pc;
  } exp_t;

`ifdef FETCH_PERF_EN
  localparam int EXP_STALL = 5;
  localparam int EXP_FETCH = 3;
`else
  localparam int EXP_STALL = 0;
  localparam int EXP_FETCH = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  start_addr = '0;
  logic        redirect = 1'b0;
  logic [3:0]  redirect_addr = '0;
  logic        halt = 1'b0;
  logic        busy;
  logic [15:0] fetch_count, stall_count;
  logic        ready = 1'b1;

  logic        tb_pre = 1'b0;
  logic        tb_wr = 1'b0;
  logic [3:0]  tb_addr = '0;
  logic [19:0] tb_data = '0;

  instr_fetch_unit_if #(.ADDR_W(4), .DATA_W(20)) bus ();
  assign bus.instr_ready = ready;

  instr_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .start_addr    (start_addr),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .halt          (halt),
    .busy          (busy),
    .fetch_count   (fetch_count),
    .stall_count   (stall_count),
    .bus           (bus.master)
  );

  register_file u_rf (
    .clk      (clk),
    .reset    (reset),
    .address  (tb_pre ? tb_addr : bus.mem_address),
    .rd       (bus.mem_rd),
    .wr       (tb_pre ? tb_wr : bus.mem_wr),
    .in_data  (tb_data),
    .out_data (bus.mem_out_data)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          n_acc    = 0;
  int          rd_cnt   = 0;
  int          acc_cyc[$];
  exp_t        exp_q[$];
  logic [19:0] mem_model [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: a handshake seen mid-cycle completes at the next edge.
  always @(negedge clk) begin
    if (!reset && bus.mem_rd) rd_cnt++;
    if (!reset && bus.instr_valid && bus.instr_ready) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_instr", bus.instr, e.instr);
        check("sb_pc", bus.instr_pc, e.pc);
      end
      acc_cyc.push_back(cyc);
      n_acc++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic preload(input logic [3:0] a, input logic [19:0] d);
    @(negedge clk);
    tb_pre = 1'b1; tb_wr = 1'b1; tb_addr = a; tb_data = d;
    @(negedge clk);
    tb_pre = 1'b0; tb_wr = 1'b0;
    mem_model[a] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic push_exp(input logic [3:0] a);
    exp_t e;
    e.instr = mem_model[a];
    e.pc    = a;
    exp_q.push_back(e);
  endtask

  // Returns just after the monitor has counted the target handshake; the
  // accepting edge is the next rising edge.
  task automatic wait_acc(input int target);
    for (int i = 0; i < 200 && n_acc < target; i++) begin
      @(negedge clk);
      #1;
    end
    check("wait_acc", n_acc, target);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) @(posedge clk);
    #1 check("wait_idle_busy", busy, 1'b0);
  endtask

  task automatic pulse_start(input logic [3:0] a, output int st_cyc);
    @(negedge clk);
    start = 1'b1; start_addr = a; st_cyc = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Halt pulse placed in the ISSUE cycle that follows the next accept.
  task automatic halt_after_next_accept();
    @(posedge clk);
    #1 halt = 1'b1;
    @(posedge clk);
    #1 halt = 1'b0;
  endtask

  // Fetch n (>=2) sequential instructions from sa, then halt after the last.
  task automatic run_prog(input logic [3:0] sa, input int n, output int st_cyc);
    int base;
    logic [3:0] a;
    base = n_acc;
    a = sa;
    for (int i = 0; i < n; i++) begin
      push_exp(a);
      a = a + 4'd1;
    end
    pulse_start(sa, st_cyc);
    wait_acc(base + n - 1);
    halt_after_next_accept();
    wait_idle();
    check("run_acc_total", n_acc, base + n);
  endtask

  initial begin
    int st, base, rd0;
    for (int i = 0; i < 16; i++) mem_model[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_valid", bus.instr_valid, 1'b0);
    check("rst_mem_rd", bus.mem_rd, 1'b0);
    check("rst_mem_wr", bus.mem_wr, 1'b0);
    check("rst_mem_addr", bus.mem_address, 4'h0);
    check("rst_instr", bus.instr, 20'h0);
    check("rst_instr_pc", bus.instr_pc, 4'h0);
    check("rst_fetch_cnt", fetch_count, 16'd0);
    check("rst_stall_cnt", stall_count, 16'd0);

    for (int i = 0; i < 16; i++) preload(4'(i), 20'h00010 + 20'(i));
    preload(4'h8, 20'h88888);
    preload(4'h9, 20'h99999);

    // 1: straight-line fetch, latency and throughput
    base = n_acc; rd0 = rd_cnt;
    run_prog(4'h0, 4, st);
    check("t1_first_latency", acc_cyc[base] - st, 3);
    for (int i = 1; i < 4; i++)
      check("t1_spacing", acc_cyc[base + i] - acc_cyc[base + i - 1], 3);
    check("t1_rd_pulses", rd_cnt - rd0, 4);

    // 2: decode stalls 5 cycles on pc=1
    do_reset();
    base = n_acc;
    push_exp(4'h0); push_exp(4'h1); push_exp(4'h2);
    pulse_start(4'h0, st);
    wait_acc(base + 1);
    @(posedge clk);
    #1 ready = 1'b0;
    for (int i = 0; i < 20 && !bus.instr_valid; i++) @(negedge clk);
    rd0 = rd_cnt;
    for (int i = 0; i < 5; i++) begin
      check("t2_stall_valid", bus.instr_valid, 1'b1);
      check("t2_stall_instr", bus.instr, 20'h00011);
      check("t2_stall_pc", bus.instr_pc, 4'h1);
      check("t2_stall_no_rd", bus.mem_rd, 1'b0);
      @(posedge clk);
      #1;
    end
    ready = 1'b1;
    check("t2_rd_during_stall", rd_cnt - rd0, 0);
    wait_acc(base + 2);
    halt_after_next_accept();
    wait_idle();
    check("t2_stall_count", stall_count, EXP_STALL);
    check("t2_fetch_count", fetch_count, EXP_FETCH);

    // 3: PC wrap E -> F -> 0
    preload(4'hE, 20'hAAAAA);
    preload(4'hF, 20'hBBBBB);
    preload(4'h0, 20'hCCCCC);
    run_prog(4'hE, 3, st);

    // 4: redirect to 8 during WAIT of pc=2
    base = n_acc;
    push_exp(4'h0); push_exp(4'h1); push_exp(4'h8); push_exp(4'h9);
    pulse_start(4'h0, st);
    wait_acc(base + 2);
    @(posedge clk);          // pc=1 accepted, ISSUE pc=2
    @(posedge clk);          // WAIT pc=2
    #1 redirect = 1'b1; redirect_addr = 4'h8;
    check("t4_valid_in_wait", bus.instr_valid, 1'b0);
    @(posedge clk);
    #1 redirect = 1'b0;
    check("t4_redirect_rd", bus.mem_rd, 1'b1);
    check("t4_redirect_addr", bus.mem_address, 4'h8);
    wait_acc(base + 3);
    halt_after_next_accept();
    wait_idle();

    // 5: halt during ISSUE of pc=5, then quiet, then restart
    preload(4'h4, 20'h44444);
    preload(4'h5, 20'h55555);
    rd0 = rd_cnt;
    run_prog(4'h4, 2, st);
    check("t5_rd_pulses", rd_cnt - rd0, 2);
    rd0 = rd_cnt;
    repeat (10) @(posedge clk);
    #1 check("t5_idle_no_rd", rd_cnt - rd0, 0);
    check("t5_idle_busy", busy, 1'b0);
    base = n_acc;
    run_prog(4'h8, 2, st);
    check("t5_restart_latency", acc_cyc[base] - st, 3);

    // 6: reset during WAIT
    pulse_start(4'h0, st);   // now in ISSUE
    @(posedge clk);          // WAIT
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("t6_busy", busy, 1'b0);
    check("t6_valid", bus.instr_valid, 1'b0);
    check("t6_mem_rd", bus.mem_rd, 1'b0);
    check("t6_mem_addr", bus.mem_address, 4'h0);
    check("t6_instr", bus.instr, 20'h0);
    check("t6_instr_pc", bus.instr_pc, 4'h0);
    check("t6_fetch_cnt", fetch_count, 16'd0);
    repeat (6) @(posedge clk);
    #1 check("t6_stays_idle", {busy, bus.instr_valid}, 2'b00);

    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_instr_fetch_unit
